// File: rtl/seg7_scan_driver.sv
// Eight-digit time-multiplexed seven-segment driver.
// Each digit slot begins with a blank window and then a PWM-controlled lit
// window. The segment patterns are snapshotted once per frame, so every
// frame shows one coherent set of digits.
//
// state                       | meaning
// ----------------------------+-----------------------------------------------
// idle  (running=0)           | disabled or just out of reset; counters at (0,0)
// scan  (running=1)           | counters advance every cycle through the frame
module seg7_scan_driver #(
   parameter int STEP           = 1024,
   parameter int BLANK          = 256,
   parameter int SEG_ACTIVE_LOW = 1,
   parameter int AN_ACTIVE_LOW  = 1
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       enable,
   input  logic [3:0] brightness,
   input  logic [7:0] seg_in_0,
   input  logic [7:0] seg_in_1,
   input  logic [7:0] seg_in_2,
   input  logic [7:0] seg_in_3,
   input  logic [7:0] seg_in_4,
   input  logic [7:0] seg_in_5,
   input  logic [7:0] seg_in_6,
   input  logic [7:0] seg_in_7,
   output logic [7:0] seg_out,
   output logic [7:0] an_out,
   output logic       frame_start
);

   localparam int SLOT    = BLANK + 16 * STEP;
   localparam int CW      = $clog2(SLOT);
   localparam int SLOT_M1 = SLOT - 1;

   localparam logic [CW-1:0] SLOT_LAST = SLOT_M1[CW-1:0];
   localparam logic [CW-1:0] ONE_S     = 1;
   localparam logic [CW:0]   BLANK_C   = BLANK[CW:0];
   localparam logic [CW:0]   STEP_C    = STEP[CW:0];
   localparam logic [CW:0]   ONE_C     = 1;
   localparam logic [7:0]    SEG_POL   = (SEG_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
   localparam logic [7:0]    AN_POL    = (AN_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;

   logic          running;
   logic [2:0]    digit;
   logic [CW-1:0] slot_cnt;
   logic [3:0]    bl;
   logic [7:0]    snap [8];

   logic [2:0]    digit_nxt;
   logic [CW-1:0] slot_nxt;
   logic          load_bl;
   logic          load_snap;
   logic [CW:0]   slot_ext;
   logic [CW:0]   lit_end;
   logic          lit;
   logic [7:0]    an_log;
   logic [7:0]    seg_log;
   logic          fs_nxt;

   // Next counter position; a fresh enable always restarts at digit 0, slot 0.
   always_comb begin
      digit_nxt = digit;
      slot_nxt  = slot_cnt;
      if (!enable || !running) begin
         digit_nxt = 3'd0;
         slot_nxt  = '0;
      end else if (slot_cnt == SLOT_LAST) begin
         digit_nxt = digit + 3'd1;
         slot_nxt  = '0;
      end else begin
         slot_nxt = slot_cnt + ONE_S;
      end
   end

   // Output decode from next-state so the registered pins line up with the counters.
   // Slot cycle 0 is always blank, so using the held bl/snap here is safe even
   // on the edge where they reload.
   always_comb begin
      load_bl   = enable && (slot_nxt == '0);
      load_snap = load_bl && (digit_nxt == 3'd0);
      slot_ext  = {1'b0, slot_nxt};
      lit_end   = BLANK_C + STEP_C * ({{(CW-3){1'b0}}, bl} + ONE_C);
      lit       = enable && (slot_ext >= BLANK_C) && (slot_ext < lit_end);
      an_log    = lit ? (8'b1 << digit_nxt) : 8'h00;
      seg_log   = lit ? snap[digit_nxt] : 8'h00;
      fs_nxt    = load_snap;
   end

   // Counters, run flag and registered pin outputs.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         running     <= 1'b0;
         digit       <= 3'd0;
         slot_cnt    <= '0;
         seg_out     <= SEG_POL;
         an_out      <= AN_POL;
         frame_start <= 1'b0;
      end else begin
         running     <= enable;
         digit       <= digit_nxt;
         slot_cnt    <= slot_nxt;
         seg_out     <= seg_log ^ SEG_POL;
         an_out      <= an_log ^ AN_POL;
         frame_start <= fs_nxt;
      end
   end

   // Brightness latch, reloaded at the start of every digit slot.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         bl <= 4'd0;
      end else if (load_bl) begin
         bl <= brightness;
      end
   end

   // Per-frame snapshot of all segment patterns.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int k = 0; k < 8; k++) snap[k] <= 8'h00;
      end else if (load_snap) begin
         snap[0] <= seg_in_0;
         snap[1] <= seg_in_1;
         snap[2] <= seg_in_2;
         snap[3] <= seg_in_3;
         snap[4] <= seg_in_4;
         snap[5] <= seg_in_5;
         snap[6] <= seg_in_6;
         snap[7] <= seg_in_7;
      end
   end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver with STEP=2, BLANK=2 (34-cycle slots, 272-cycle frames).
module tb_seg7_scan_driver;

   localparam int STEP  = 2;
   localparam int BLANK = 2;
   localparam int SLOT  = BLANK + 16 * STEP;
   localparam int FRAME = 8 * SLOT;

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic       enable = 1'b1;
   logic [3:0] brightness = 4'd0;
   logic [7:0] si [8];
   logic [7:0] seg_out;
   logic [7:0] an_out;
   logic       frame_start;

   int total = 0;
   int bad   = 0;

   int         m_t  = -1;
   int         m_bl = 0;
   int         m_d  = 0;
   int         m_sc = 0;
   logic [7:0] m_snap [8];
   logic [7:0] exp_an  = 8'hFF;
   logic [7:0] exp_seg = 8'hFF;
   logic       exp_fs  = 1'b0;

   seg7_scan_driver #(.STEP(STEP), .BLANK(BLANK), .SEG_ACTIVE_LOW(1), .AN_ACTIVE_LOW(1)) dut (
      .clock(clock), .reset(reset), .enable(enable), .brightness(brightness),
      .seg_in_0(si[0]), .seg_in_1(si[1]), .seg_in_2(si[2]), .seg_in_3(si[3]),
      .seg_in_4(si[4]), .seg_in_5(si[5]), .seg_in_6(si[6]), .seg_in_7(si[7]),
      .seg_out(seg_out), .an_out(an_out), .frame_start(frame_start)
   );

   always #5 clock = ~clock;

   // Advance one clock and update the reference model: m_t is the cycle index
   // within the running frame, or -1 while dark.
   task automatic step();
      logic lit;
      @(posedge clock);
      if (!reset) begin
         m_t = -1; m_bl = 0;
         for (int k = 0; k < 8; k++) m_snap[k] = 8'h00;
      end else if (!enable) begin
         m_t = -1;
      end else begin
         m_t = (m_t < 0) ? 0 : (m_t + 1) % FRAME;
         if (m_t % SLOT == 0) begin
            m_bl = int'(brightness);
            if (m_t == 0) for (int k = 0; k < 8; k++) m_snap[k] = si[k];
         end
      end
      lit = 1'b0; m_d = 0; m_sc = 0;
      if (m_t >= 0) begin
         m_d  = m_t / SLOT;
         m_sc = m_t % SLOT;
         lit  = (m_sc >= BLANK) && (m_sc < BLANK + (m_bl + 1) * STEP);
      end
      exp_an  = lit ? ~(8'd1 << m_d) : 8'hFF;
      exp_seg = lit ? ~m_snap[m_d] : 8'hFF;
      exp_fs  = (m_t == 0);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b0; enable = 1'b1; si[0] = 8'h3F;
      for (int i = 0; i < 5; i++) begin
         step();
         total++;
         if ({an_out, seg_out, frame_start} !== {8'hFF, 8'hFF, 1'b0}) begin
            bad++;
            $display("FAIL reset cyc=%0d got an=%h seg=%h fs=%b want an=ff seg=ff fs=0", i, an_out, seg_out, frame_start);
         end
      end
   endtask

   task automatic test_normal();
      brightness = 4'd15;
      for (int k = 0; k < 8; k++) si[k] = 8'h10 + 8'(k);
      reset = 1'b1;
      for (int i = 0; i <= FRAME + 5; i++) begin
         step();
         total++;
         if ({an_out, seg_out, frame_start} !== {exp_an, exp_seg, exp_fs}) begin
            bad++;
            $display("FAIL normal t=%0d got an=%h seg=%h fs=%b want an=%h seg=%h fs=%b", m_t, an_out, seg_out, frame_start, exp_an, exp_seg, exp_fs);
         end
         if (i == 0 || i == FRAME) begin
            total++;
            if (frame_start !== 1'b1) begin bad++; $display("FAIL frame_pulse i=%0d got %b want 1", i, frame_start); end
         end
         if (i == 1) begin
            total++;
            if (an_out !== 8'hFF) begin bad++; $display("FAIL blank_win got %h want ff", an_out); end
         end
         if (i == 33) begin
            total++;
            if ({an_out, seg_out} !== {8'hFE, 8'hEF}) begin bad++; $display("FAIL digit0_lit got %h/%h want fe/ef", an_out, seg_out); end
         end
         if (i == 7 * SLOT + 20) begin
            total++;
            if ({an_out, seg_out} !== {8'h7F, 8'hE8}) begin bad++; $display("FAIL digit7_lit got %h/%h want 7f/e8", an_out, seg_out); end
         end
      end
   endtask

   task automatic test_brightness();
      int i;
      brightness = 4'd0;
      for (i = 0; i < 2 * SLOT && m_sc != SLOT - 1; i++) begin
         step();
         total++;
         if ({an_out, seg_out, frame_start} !== {exp_an, exp_seg, exp_fs}) begin
            bad++;
            $display("FAIL bright_pre t=%0d got an=%h seg=%h want an=%h seg=%h", m_t, an_out, seg_out, exp_an, exp_seg);
         end
      end
      total++;
      if (m_sc != SLOT - 1) begin bad++; $display("FAIL bright_align timeout got sc=%0d want %0d", m_sc, SLOT - 1); end
      for (i = 0; i < 2 * SLOT; i++) begin
         step();
         if (i == 10) brightness = 4'd7;
         total++;
         if ({an_out, seg_out, frame_start} !== {exp_an, exp_seg, exp_fs}) begin
            bad++;
            $display("FAIL bright t=%0d got an=%h seg=%h want an=%h seg=%h", m_t, an_out, seg_out, exp_an, exp_seg);
         end
         if (i == 3 || i == SLOT + 17) begin
            total++;
            if (an_out === 8'hFF) begin bad++; $display("FAIL bright_lit i=%0d got an=%h want one active", i, an_out); end
         end
         if (i == 4 || i == 20 || i == SLOT + 18) begin
            total++;
            if (an_out !== 8'hFF) begin bad++; $display("FAIL bright_dark i=%0d got an=%h want ff", i, an_out); end
         end
      end
   endtask

   task automatic test_snapshot();
      int i;
      si[3] = 8'h06;
      for (i = 0; i < 2 * FRAME && !(m_t == 0); i++) begin
         step();
         total++;
         if ({an_out, seg_out, frame_start} !== {exp_an, exp_seg, exp_fs}) begin
            bad++;
            $display("FAIL snap_pre t=%0d got an=%h seg=%h want an=%h seg=%h", m_t, an_out, seg_out, exp_an, exp_seg);
         end
      end
      total++;
      if (m_t != 0) begin bad++; $display("FAIL snap_align timeout got t=%0d want 0", m_t); end
      for (i = 0; i < 2 * FRAME; i++) begin
         step();
         if (m_d == 1 && m_sc == 5 && i < FRAME) si[3] = 8'h5B;
         total++;
         if ({an_out, seg_out, frame_start} !== {exp_an, exp_seg, exp_fs}) begin
            bad++;
            $display("FAIL snap t=%0d got an=%h seg=%h want an=%h seg=%h", m_t, an_out, seg_out, exp_an, exp_seg);
         end
         if (m_d == 3 && m_sc == 3) begin
            total++;
            if (seg_out !== ((i < FRAME) ? 8'hF9 : 8'hA4)) begin
               bad++;
               $display("FAIL snap_digit3 i=%0d got %h want %h", i, seg_out, (i < FRAME) ? 8'hF9 : 8'hA4);
            end
         end
      end
   endtask

   task automatic test_enable();
      int i;
      for (i = 0; i < 2 * FRAME && !(m_d == 4 && m_sc == 5); i++) begin
         step();
         total++;
         if ({an_out, seg_out, frame_start} !== {exp_an, exp_seg, exp_fs}) begin
            bad++;
            $display("FAIL en_pre t=%0d got an=%h seg=%h want an=%h seg=%h", m_t, an_out, seg_out, exp_an, exp_seg);
         end
      end
      total++;
      if (an_out !== 8'hEF) begin bad++; $display("FAIL en_align got an=%h want ef", an_out); end
      enable = 1'b0;
      for (i = 0; i < 50; i++) begin
         step();
         total++;
         if ({an_out, seg_out, frame_start} !== {8'hFF, 8'hFF, 1'b0}) begin
            bad++;
            $display("FAIL en_off i=%0d got an=%h seg=%h fs=%b want ff/ff/0", i, an_out, seg_out, frame_start);
         end
      end
      enable = 1'b1;
      for (i = 0; i < 40; i++) begin
         step();
         total++;
         if ({an_out, seg_out, frame_start} !== {exp_an, exp_seg, exp_fs}) begin
            bad++;
            $display("FAIL en_on t=%0d got an=%h seg=%h fs=%b want an=%h seg=%h fs=%b", m_t, an_out, seg_out, frame_start, exp_an, exp_seg, exp_fs);
         end
         if (i == 0) begin
            total++;
            if (frame_start !== 1'b1) begin bad++; $display("FAIL en_restart got fs=%b want 1", frame_start); end
         end
      end
   endtask

   task automatic test_async_reset();
      int i;
      for (i = 0; i < 2 * FRAME && !(m_d == 2 && m_sc == 6); i++) step();
      #2 reset = 1'b0;
      #1;
      total++;
      if ({an_out, seg_out, frame_start} !== {8'hFF, 8'hFF, 1'b0}) begin
         bad++;
         $display("FAIL async_reset got an=%h seg=%h fs=%b want ff/ff/0", an_out, seg_out, frame_start);
      end
      step(); step();
      reset = 1'b1;
      for (i = 0; i < 60; i++) begin
         step();
         total++;
         if ({an_out, seg_out, frame_start} !== {exp_an, exp_seg, exp_fs}) begin
            bad++;
            $display("FAIL post_reset t=%0d got an=%h seg=%h fs=%b want an=%h seg=%h fs=%b", m_t, an_out, seg_out, frame_start, exp_an, exp_seg, exp_fs);
         end
         if (i == 0) begin
            total++;
            if (frame_start !== 1'b1) begin bad++; $display("FAIL post_reset_fs got %b want 1", frame_start); end
         end
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 3 * FRAME; i++) begin
         step();
         if ($urandom_range(19) == 0) si[$urandom_range(7)] = 8'($urandom);
         if ($urandom_range(29) == 0) brightness = 4'($urandom);
         total++;
         if ({an_out, seg_out, frame_start} !== {exp_an, exp_seg, exp_fs}) begin
            bad++;
            $display("FAIL random t=%0d got an=%h seg=%h fs=%b want an=%h seg=%h fs=%b", m_t, an_out, seg_out, frame_start, exp_an, exp_seg, exp_fs);
         end
         total++;
         if ($countones(~an_out) > 1) begin
            bad++;
            $display("FAIL one_anode t=%0d got an=%h want at most one active", m_t, an_out);
         end
      end
   endtask

   initial begin
      for (int k = 0; k < 8; k++) begin si[k] = 8'h00; m_snap[k] = 8'h00; end
      test_reset();
      test_normal();
      test_brightness();
      test_snapshot();
      test_enable();
      test_async_reset();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
- Time-multiplexed 8-digit seven-segment driver, directly downstream of the SoC top-level `externalPins_gpio_seg_0..7` outputs.
- Takes eight static 8-bit segment patterns and drives one shared segment bus plus eight digit-select (anode) lines on the board.
- Adds per-frame snapshotting so each frame is coherent, inter-digit blanking to prevent ghosting, and 16-level PWM brightness.

Parameters:
- STEP, 1024: cycles per brightness step; 16 steps make up the lit portion of a digit slot.
- BLANK, 256: cycles at the start of each digit slot with all anodes off.
- SEG_ACTIVE_LOW, 1: 1 = segment lines are active-low at the pins.
- AN_ACTIVE_LOW, 1: 1 = anode lines are active-low at the pins.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous reset, active-low (0 = in reset)
- enable  in  1  1 = scanning; 0 = display dark
- brightness  in  4  lit steps minus 1 (0 = dimmest, 15 = full)
- seg_in_0 .. seg_in_7  in  8 each  segment pattern per digit, bit=1 means lit, bit7 = DP (same encoding as gpio_seg_*)
- seg_out  out  8  shared segment bus at the pins, polarity per SEG_ACTIVE_LOW
- an_out  out  8  digit selects at the pins, bit k = digit k, polarity per AN_ACTIVE_LOW
- frame_start  out  1  one-cycle pulse at the first cycle of digit 0's slot

Behaviour:
- Reset (reset=0, async):
  - Counters: digit=0, slot_cnt=0, brightness latch=0, snapshot=0.
  - Outputs: seg_out = all segments inactive, an_out = all anodes inactive, frame_start=0.
- Slot length: SLOT = BLANK + 16*STEP cycles. Frame length: 8*SLOT cycles.
- Counters:
  - slot_cnt runs 0..SLOT-1 and wraps to 0.
  - digit increments on each wrap, 0..7, and wraps 7->0.
- Outputs are registered and reflect counter state (digit, slot_cnt) in the same cycle; the implementation computes them from next-state.
- Per-cycle output with enable=1:
  - Blank window, slot_cnt < BLANK: an_out all inactive, seg_out all inactive.
  - Lit window, BLANK <= slot_cnt < BLANK + (bl+1)*STEP: only an_out[digit] active; seg_out = snapshot[digit] mapped to pin polarity. bl = latched brightness.
  - Remainder of slot: an_out and seg_out all inactive.
  - Never more than one anode active in any cycle.
- Brightness latch:
  - bl is loaded from `brightness` on the edge entering slot_cnt=0 of any digit.
  - A mid-slot change takes effect at the next slot.
- Snapshot:
  - All eight seg_in values are captured on the edge entering (digit 0, slot_cnt 0).
  - seg_in changes mid-frame are invisible until the next frame.
- frame_start: 1 exactly in cycles where digit=0 and slot_cnt=0 with enable=1; otherwise 0.
- enable=0:
  - On the next edge the counters go to (0,0) and are held there.
  - Outputs all inactive, frame_start=0; snapshot and bl hold.
- enable 0->1: the first enabled cycle is (0,0). frame_start=1 in that cycle, and the snapshot and bl load on that same edge.
- Reset asserted mid-frame: outputs inactive immediately (asynchronously). After release, operation follows the enable rules; if enable=1 at release, the first cycle is (0,0) with frame_start=1.
- Polarity: pin value = logical value XOR polarity parameter, applied to all 8 bits of each bus.
- Counter widths: sized by clog2 of SLOT and 8. No overflow for any legal parameters, with STEP>=1 and BLANK>=1.

Test Plan (STEP=2, BLANK=2, so SLOT=34 and frame=272; both polarities active-low):
- Reset held with enable=1 and seg_in_0=0x3F -> an_out=0xFF, seg_out=0xFF, frame_start=0 throughout; async assertion mid-frame forces 0xFF/0xFF before the next edge.
- Release with enable=1, brightness=15, seg_in_k=0x10+k:
  - frame_start=1 in cycle 0.
  - Slot cycles 0..1: an_out=0xFF.
  - Slot cycles 2..33: an_out=0xFE, seg_out=0xEF.
  - Digit 7 lit window: an_out=0x7F, seg_out=~0x17=0xE8.
  - frame_start repeats every 272 cycles.
- brightness=0: digit lit only in slot cycles 2..3, 0xFF in cycles 4..33. Changing brightness to 7 at slot cycle 10 -> current slot unchanged; next slot lit cycles 2..17.
- seg_in_3 changed 0x06->0x5B during digit 1's slot -> digit 3 still shows ~0x06=0xF9 this frame and ~0x5B=0xA4 from the next frame.
- enable dropped during digit 4's lit window -> next cycle an_out=0xFF, seg_out=0xFF. Re-enable after 50 cycles -> first enabled cycle is digit 0, slot_cnt 0, frame_start=1.
- Scoreboard check over 3 full frames with random seg_in and brightness: popcount(active anodes) <= 1 in every cycle.
